ship_placement_ctrl: RTL and testbench

Consumes the confirmed ship count from the decision stage and runs the ship-placement phase for one player. It moves a cursor over a GRID_N x GRID_N board and places ships of increasing length (1, 2, 3, …). Each placement is checked for bounds and overlap. The block maintains the occupancy bitmap used by the VGA renderer and signals finished_placing once the decided number of ships is on the board.

---
 rtl/ship_placement_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_ship_placement_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ship_placement_ctrl.sv
// Ship placement controller: cursor movement, rotation, bounds/overlap
// checked placement of ships of length 1..N, and the board occupancy bitmap.
//
// Ports:
//   clk, rst                   - clock, synchronous active-low reset
//   ships_decided              - pulse: ship count confirmed
//   player_ship_amount_define  - ship count, valid with ships_decided
//   btn_up/down/left/right     - cursor move pulses
//   btn_rotate                 - toggle orientation pulse
//   btn_place                  - attempt placement pulse
//   cursor_row, cursor_col     - cursor cell
//   orientation                - 0 = horizontal (+col), 1 = vertical (+row)
//   cur_ship_len               - length of the ship being placed
//   ships_placed               - ships committed so far
//   board_mask                 - occupancy, bit = row*GRID_N+col
//   place_error                - pulse: placement rejected
//   placing_active             - high while placing or checking
//   finished_placing           - high once all ships are on the board

module ship_placement_ctrl #(
    parameter int GRID_N    = 5,
    parameter int MAX_SHIPS = 5,
    parameter int CW        = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ships_decided,
    input  logic [CW-1:0]              player_ship_amount_define,
    input  logic                       btn_up,
    input  logic                       btn_down,
    input  logic                       btn_left,
    input  logic                       btn_right,
    input  logic                       btn_rotate,
    input  logic                       btn_place,
    output logic [CW-1:0]              cursor_row,
    output logic [CW-1:0]              cursor_col,
    output logic                       orientation,
    output logic [CW-1:0]              cur_ship_len,
    output logic [CW-1:0]              ships_placed,
    output logic [GRID_N*GRID_N-1:0]   board_mask,
    output logic                       place_error,
    output logic                       placing_active,
    output logic                       finished_placing
);

    localparam int CELLS = GRID_N * GRID_N;
    localparam int IW    = $clog2(CELLS);
    localparam logic [CW-1:0] LAST  = CW'(GRID_N - 1);
    localparam logic [CW:0]   LASTX = (CW+1)'(GRID_N - 1);
    localparam logic [CW-1:0] MAXS  = CW'(MAX_SHIPS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLACE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   target;
    logic            decide_ok;
    logic [CW:0]     anchor;
    logic [CW:0]     end_pos;
    logic            in_bounds;
    logic [CELLS-1:0] footprint;
    logic            overlap;
    logic            place_ok;
    int              fr;
    int              fc;

    assign cur_ship_len     = ships_placed + CW'(1);
    assign placing_active   = (state == S_PLACE) || (state == S_CHECK);
    assign finished_placing = (state == S_DONE);

    assign decide_ok = ships_decided
                    && (player_ship_amount_define != '0)
                    && (player_ship_amount_define <= MAXS);

    // Bounds sum is one bit wider than the coordinates so it cannot wrap.
    assign anchor    = orientation ? {1'b0, cursor_row} : {1'b0, cursor_col};
    assign end_pos   = anchor + {1'b0, cur_ship_len} - (CW+1)'(1);
    assign in_bounds = (end_pos <= LASTX);

    // Cells falling off the board are dropped; in_bounds rejects those cases.
    always_comb begin
        footprint = '0;
        fr        = 0;
        fc        = 0;
        for (int k = 0; k < GRID_N; k++) begin
            if (k < int'(cur_ship_len)) begin
                fr = int'(cursor_row) + (orientation ? k : 0);
                fc = int'(cursor_col) + (orientation ? 0 : k);
                if (fr < GRID_N && fc < GRID_N) begin
                    footprint[IW'(fr * GRID_N + fc)] = 1'b1;
                end
            end
        end
    end

    assign overlap  = |(footprint & board_mask);
    assign place_ok = in_bounds && !overlap;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (decide_ok) begin
                    state_n = S_PLACE;
                end
            end
            S_PLACE: begin
                if (btn_place) begin
                    state_n = S_CHECK;
                end
            end
            S_CHECK: begin
                if (place_ok && (cur_ship_len == target)) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_PLACE;
                end
            end
            S_DONE: begin
                state_n = S_DONE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cursor_row   <= '0;
            cursor_col   <= '0;
            orientation  <= 1'b0;
            ships_placed <= '0;
            board_mask   <= '0;
            place_error  <= 1'b0;
            target       <= '0;
        end else begin
            place_error <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (decide_ok) begin
                        target       <= player_ship_amount_define;
                        board_mask   <= '0;
                        cursor_row   <= '0;
                        cursor_col   <= '0;
                        orientation  <= 1'b0;
                        ships_placed <= '0;
                    end
                end
                S_PLACE: begin
                    // One action per cycle; a saturated move still
                    // consumes the cycle and drops lower-priority pulses.
                    if (btn_place) begin
                        // cursor and orientation freeze for CHECK
                    end else if (btn_rotate) begin
                        orientation <= ~orientation;
                    end else if (btn_up) begin
                        if (cursor_row != '0) begin
                            cursor_row <= cursor_row - CW'(1);
                        end
                    end else if (btn_down) begin
                        if (cursor_row != LAST) begin
                            cursor_row <= cursor_row + CW'(1);
                        end
                    end else if (btn_left) begin
                        if (cursor_col != '0) begin
                            cursor_col <= cursor_col - CW'(1);
                        end
                    end else if (btn_right) begin
                        if (cursor_col != LAST) begin
                            cursor_col <= cursor_col + CW'(1);
                        end
                    end
                end
                S_CHECK: begin
                    if (place_ok) begin
                        board_mask   <= board_mask | footprint;
                        ships_placed <= ships_placed + CW'(1);
                    end else begin
                        place_error <= 1'b1;
                    end
                end
                S_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ship_placement_ctrl.sv
// Directed testbench for ship_placement_ctrl.
// Hand-computed expectations for placement, errors, saturation and reset.

module tb_ship_placement_ctrl;

    localparam int GRID_N = 5;
    localparam int CW     = 3;

    localparam logic [5:0] B_P = 6'b100000;
    localparam logic [5:0] B_O = 6'b010000;
    localparam logic [5:0] B_U = 6'b001000;
    localparam logic [5:0] B_D = 6'b000100;
    localparam logic [5:0] B_L = 6'b000010;
    localparam logic [5:0] B_R = 6'b000001;

    logic                      clk;
    logic                      rst;
    logic                      ships_decided;
    logic [CW-1:0]             amount;
    logic [5:0]                btns;
    logic [CW-1:0]             cursor_row;
    logic [CW-1:0]             cursor_col;
    logic                      orientation;
    logic [CW-1:0]             cur_ship_len;
    logic [CW-1:0]             ships_placed;
    logic [GRID_N*GRID_N-1:0]  board_mask;
    logic                      place_error;
    logic                      placing_active;
    logic                      finished_placing;

    int checks;
    int errors;

    ship_placement_ctrl #(
        .GRID_N(GRID_N),
        .MAX_SHIPS(5),
        .CW(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ships_decided(ships_decided),
        .player_ship_amount_define(amount),
        .btn_up(btns[3]),
        .btn_down(btns[2]),
        .btn_left(btns[1]),
        .btn_right(btns[0]),
        .btn_rotate(btns[4]),
        .btn_place(btns[5]),
        .cursor_row(cursor_row),
        .cursor_col(cursor_col),
        .orientation(orientation),
        .cur_ship_len(cur_ship_len),
        .ships_placed(ships_placed),
        .board_mask(board_mask),
        .place_error(place_error),
        .placing_active(placing_active),
        .finished_placing(finished_placing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [5:0] b);
        btns = b;
        cyc();
        btns = '0;
    endtask

    task automatic moves(input logic [5:0] b, input int n);
        for (int i = 0; i < n; i++) press(b);
    endtask

    // Returns at t+2: commit or error visible.
    task automatic place();
        press(B_P);
        cyc();
    endtask

    task automatic decide(input logic [CW-1:0] a);
        amount        = a;
        ships_decided = 1'b1;
        cyc();
        ships_decided = 1'b0;
        amount        = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        ships_decided = 1'b0;
        amount        = '0;
        btns          = '0;

        // reset state
        do_reset();
        check("rst_row", 32'(cursor_row), 0);
        check("rst_col", 32'(cursor_col), 0);
        check("rst_orient", 32'(orientation), 0);
        check("rst_len", 32'(cur_ship_len), 1);
        check("rst_placed", 32'(ships_placed), 0);
        check("rst_mask", 32'(board_mask), 0);
        check("rst_active", 32'(placing_active), 0);
        check("rst_done", 32'(finished_placing), 0);

        // two ships, horizontal
        decide(3'd2);
        check("t1_active", 32'(placing_active), 1);
        place();
        check("t1_mask1", 32'(board_mask), 32'h1);
        check("t1_placed1", 32'(ships_placed), 1);
        check("t1_len2", 32'(cur_ship_len), 2);
        check("t1_noerr", 32'(place_error), 0);
        moves(B_R, 2);
        check("t1_col2", 32'(cursor_col), 2);
        place();
        check("t1_mask2", 32'(board_mask), 32'hD);
        check("t1_placed2", 32'(ships_placed), 2);
        check("t1_fin", 32'(finished_placing), 1);
        check("t1_inactive", 32'(placing_active), 0);
        press(B_R);
        check("t1_done_btn", 32'(cursor_col), 2);
        decide(3'd1);
        check("t1_done_dec", 32'(finished_placing), 1);
        check("t1_done_mask", 32'(board_mask), 32'hD);

        // out-of-bounds then rotate
        do_reset();
        decide(3'd3);
        place();
        moves(B_R, 2);
        place();
        check("t2_mask2", 32'(board_mask), 32'hD);
        moves(B_R, 2);
        check("t2_col4", 32'(cursor_col), 4);
        place();
        check("t2_err", 32'(place_error), 1);
        check("t2_mask_keep", 32'(board_mask), 32'hD);
        check("t2_placed_keep", 32'(ships_placed), 2);
        cyc();
        check("t2_err_pulse", 32'(place_error), 0);
        press(B_O);
        check("t2_orient", 32'(orientation), 1);
        place();
        check("t2_mask3", 32'(board_mask), 32'h421D);
        check("t2_placed3", 32'(ships_placed), 3);
        check("t2_fin", 32'(finished_placing), 1);

        // overlap; buttons during CHECK ignored
        do_reset();
        decide(3'd2);
        press(B_D);
        press(B_R);
        press(B_P);
        press(B_R);
        check("t3_mask1", 32'(board_mask), 32'h40);
        check("t3_chk_ign", 32'(cursor_col), 1);
        press(B_U);
        press(B_O);
        place();
        check("t3_ovl_err", 32'(place_error), 1);
        check("t3_ovl_mask", 32'(board_mask), 32'h40);
        check("t3_ovl_placed", 32'(ships_placed), 1);
        moves(B_D, 2);
        check("t3_row2", 32'(cursor_row), 2);
        place();
        check("t3_mask2", 32'(board_mask), 32'h10840);
        check("t3_fin", 32'(finished_placing), 1);

        // cursor saturation
        do_reset();
        decide(3'd1);
        moves(B_R, 7);
        check("t4_col_sat", 32'(cursor_col), 4);
        press(B_U);
        check("t4_row_sat0", 32'(cursor_row), 0);
        moves(B_D, 7);
        check("t4_row_sat4", 32'(cursor_row), 4);
        moves(B_L, 7);
        check("t4_col_sat0", 32'(cursor_col), 0);
        place();
        check("t4_mask", 32'(board_mask), 32'h100000);
        check("t4_fin", 32'(finished_placing), 1);

        // illegal counts and priority
        do_reset();
        decide(3'd0);
        check("t5_amt0", 32'(placing_active), 0);
        decide(3'd6);
        check("t5_amt6", 32'(placing_active), 0);
        decide(3'd2);
        check("t5_amt2", 32'(placing_active), 1);
        press(B_P | B_R);
        cyc();
        check("t5_prio_mask", 32'(board_mask), 32'h1);
        check("t5_prio_col", 32'(cursor_col), 0);
        press(B_O | B_D);
        check("t5_prio_rot", 32'(orientation), 1);
        check("t5_prio_row", 32'(cursor_row), 0);
        press(B_O);

        // reset during CHECK
        press(B_R);
        press(B_P);
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        check("t6_mask", 32'(board_mask), 0);
        check("t6_placed", 32'(ships_placed), 0);
        check("t6_col", 32'(cursor_col), 0);
        check("t6_active", 32'(placing_active), 0);
        check("t6_err", 32'(place_error), 0);
        check("t6_len", 32'(cur_ship_len), 1);
        cyc();
        check("t6_idle", 32'(placing_active), 0);
        decide(3'd1);
        check("t6_restart", 32'(placing_active), 1);
        check("t6_clean", 32'(board_mask), 0);
        place();
        check("t6_mask1", 32'(board_mask), 32'h1);
        check("t6_fin", 32'(finished_placing), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
